scan_dump_arbiter: RTL and testbench

//  Shares one byte-wide serial transmitter between NCH scan-chain dump channels.

---
 rtl/scan_dump_pkg.sv | 21 ++
 rtl/scan_dump_arbiter_rr.sv | 32 +++
 rtl/scan_dump_arbiter.sv | 178 +++++++++++++++++
 tb/tb_scan_dump_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_dump_pkg.sv
// Shared types and constants for the scan-chain dump arbiter.
package scan_dump_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        DATA = 3'd2,
        GAP  = 3'd3,
        TRL  = 3'd4
    } state_t;

    localparam logic [3:0] HDR_TAG_DEF = 4'hA;
    localparam int         CNT_W       = 16;
    localparam int         IDX_W       = 4;

    // Round-robin pointer successor: one past the last grant, wrapping at nch-1.
    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] g, input int nch);
        return (int'(g) == (nch - 1)) ? {IDX_W{1'b0}} : (g + 4'd1);
    endfunction

endpackage

// File: rtl/scan_dump_arbiter_rr.sv
// Combinational round-robin picker: first requesting channel at or above ptr, wrapping.
module rr_arbiter
    import scan_dump_pkg::*;
#(
    parameter int NCH = 8
) (
    input  logic [NCH-1:0]   req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NCH-1:0]   grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic hit_s;

    // Scan offsets from ptr upward; the first requesting channel wins.
    always_comb begin
        grant = {NCH{1'b0}};
        idx   = {IDX_W{1'b0}};
        any   = 1'b0;
        hit_s = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            for (int k = 0; k < NCH; k++) begin
                hit_s    = !any && req[k] && (k == ((int'(ptr) + i) % NCH));
                grant[k] = grant[k] | hit_s;
                idx      = hit_s ? IDX_W'(k) : idx;
                any      = any | hit_s;
            end
        end
    end

endmodule

// File: rtl/scan_dump_arbiter.sv
// Shares one byte-wide serial transmitter between NCH scan dump channels.
// Each grant produces one frame: header {HDR_TAG, id}, the channel's bytes, trailer = byte count.
module scan_dump_arbiter
    import scan_dump_pkg::*;
#(
    parameter int         NCH     = 8,
    parameter logic [3:0] HDR_TAG = HDR_TAG_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   ch_req,
    input  logic [8*NCH-1:0] ch_data,
    input  logic [NCH-1:0]   ch_vld,
    input  logic [NCH-1:0]   ch_done,
    input  logic             serial_busy,
    output logic             c_en,
    output logic [NCH-1:0]   dump_en,
    output logic [NCH-1:0]   ch_ack,
    output logic             serial_en,
    output logic [7:0]       serial_tx
);

    state_t             state_r, state_s;
    state_t             ret_r, ret_s;
    logic [IDX_W-1:0]   g_r, g_s;
    logic [IDX_W-1:0]   rr_r, rr_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               c_en_r, c_en_s;
    logic [NCH-1:0]     dump_en_r, dump_en_s;
    logic [NCH-1:0]     ch_ack_r, ch_ack_s;
    logic               serial_en_r, serial_en_s;
    logic [7:0]         serial_tx_r, serial_tx_s;

    logic [NCH-1:0]     arb_grant_s;
    logic [IDX_W-1:0]   arb_idx_s;
    logic               arb_any_s;

    logic [7:0]         sel_data_s;
    logic               sel_vld_s;
    logic               sel_done_s;
    logic               sel_hit_s;

    rr_arbiter #(.NCH(NCH)) u_rr (
        .req   (ch_req),
        .ptr   (rr_r),
        .grant (arb_grant_s),
        .idx   (arb_idx_s),
        .any   (arb_any_s)
    );

    // Route the granted channel's data, valid and done onto a single lane.
    always_comb begin
        sel_data_s = 8'h00;
        sel_vld_s  = 1'b0;
        sel_done_s = 1'b0;
        sel_hit_s  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            sel_hit_s  = (g_r == IDX_W'(i));
            sel_data_s = sel_hit_s ? ch_data[8*i +: 8] : sel_data_s;
            sel_vld_s  = sel_hit_s ? ch_vld[i]         : sel_vld_s;
            sel_done_s = sel_hit_s ? ch_done[i]        : sel_done_s;
        end
    end

    // Frame sequencer: next state and next values of every registered output.
    always_comb begin
        state_s     = state_r;
        ret_s       = ret_r;
        g_s         = g_r;
        rr_s        = rr_r;
        cnt_s       = cnt_r;
        c_en_s      = c_en_r;
        dump_en_s   = dump_en_r;
        ch_ack_s    = {NCH{1'b0}};
        serial_en_s = 1'b0;
        serial_tx_s = serial_tx_r;
        case (state_r)
            IDLE: begin
                if (arb_any_s) begin
                    g_s       = arb_idx_s;
                    dump_en_s = arb_grant_s;
                    c_en_s    = 1'b0;
                    state_s   = HDR;
                end else begin
                    c_en_s    = 1'b1;
                end
            end
            HDR: begin
                if (!serial_busy) begin
                    serial_en_s = 1'b1;
                    serial_tx_s = {HDR_TAG, g_r};
                    ret_s       = DATA;
                    state_s     = GAP;
                end else begin
                    state_s     = HDR;
                end
            end
            DATA: begin
                // A valid byte always goes out before done is looked at.
                if (!serial_busy && sel_vld_s) begin
                    serial_en_s = 1'b1;
                    serial_tx_s = sel_data_s;
                    ch_ack_s    = dump_en_r;
                    cnt_s       = cnt_r + 16'd1;
                    ret_s       = DATA;
                    state_s     = GAP;
                end else if (sel_done_s && !sel_vld_s) begin
                    state_s     = TRL;
                end else begin
                    state_s     = DATA;
                end
            end
            TRL: begin
                if (!serial_busy) begin
                    serial_en_s = 1'b1;
                    serial_tx_s = cnt_r[7:0];
                    ret_s       = IDLE;
                    state_s     = GAP;
                end else begin
                    state_s     = TRL;
                end
            end
            GAP: begin
                // One quiet cycle so the transmitter can raise busy.
                state_s = ret_r;
                if (ret_r == IDLE) begin
                    dump_en_s = {NCH{1'b0}};
                    c_en_s    = 1'b1;
                    cnt_s     = {CNT_W{1'b0}};
                    rr_s      = rr_next(g_r, NCH);
                end else begin
                    dump_en_s = dump_en_r;
                end
            end
            default: begin
                state_s   = IDLE;
                ret_s     = IDLE;
                dump_en_s = {NCH{1'b0}};
                c_en_s    = 1'b1;
                cnt_s     = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            ret_r       <= IDLE;
            g_r         <= {IDX_W{1'b0}};
            rr_r        <= {IDX_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            c_en_r      <= 1'b1;
            dump_en_r   <= {NCH{1'b0}};
            ch_ack_r    <= {NCH{1'b0}};
            serial_en_r <= 1'b0;
            serial_tx_r <= 8'h00;
        end else begin
            state_r     <= state_s;
            ret_r       <= ret_s;
            g_r         <= g_s;
            rr_r        <= rr_s;
            cnt_r       <= cnt_s;
            c_en_r      <= c_en_s;
            dump_en_r   <= dump_en_s;
            ch_ack_r    <= ch_ack_s;
            serial_en_r <= serial_en_s;
            serial_tx_r <= serial_tx_s;
        end
    end

    assign c_en      = c_en_r;
    assign dump_en   = dump_en_r;
    assign ch_ack    = ch_ack_r;
    assign serial_en = serial_en_r;
    assign serial_tx = serial_tx_r;

endmodule

// File: tb/tb_scan_dump_arbiter.sv
// Scoreboard bench for scan_dump_arbiter: expected TX bytes and grants are queued
// by the stimulus, a monitor pops and compares them as the DUT strobes.
module tb_scan_dump_arbiter;

    localparam int NCH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NCH-1:0]   ch_req;
    logic [8*NCH-1:0] ch_data;
    logic [NCH-1:0]   ch_vld;
    logic [NCH-1:0]   ch_done;
    logic             serial_busy;
    logic             c_en;
    logic [NCH-1:0]   dump_en;
    logic [NCH-1:0]   ch_ack;
    logic             serial_en;
    logic [7:0]       serial_tx;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_tx     = 0;
    logic [7:0] exp_q[$];
    int         grant_q[$];
    int         ack_cnt[NCH] = '{default: 0};
    logic [7:0] mem[NCH][0:299];
    int         rd[NCH] = '{default: 0};
    int         wr[NCH] = '{default: 0};
    logic       fin[NCH] = '{default: 1'b0};

    always #5 clk = ~clk;

    scan_dump_arbiter #(.NCH(NCH), .HDR_TAG(4'hA)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ch_req      (ch_req),
        .ch_data     (ch_data),
        .ch_vld      (ch_vld),
        .ch_done     (ch_done),
        .serial_busy (serial_busy),
        .c_en        (c_en),
        .dump_en     (dump_en),
        .ch_ack      (ch_ack),
        .serial_en   (serial_en),
        .serial_tx   (serial_tx)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_byte(input int ch, input logic [7:0] b);
        mem[ch][wr[ch]] = b;
        wr[ch]++;
    endtask

    task automatic wait_drain(input int budget, input string name);
        for (int c = 0; c < budget && exp_q.size() != 0; c++) @(negedge clk);
        check(name, exp_q.size(), 0);
    endtask

    task automatic wait_idle(input int budget, input string name);
        for (int c = 0; c < budget && dump_en != '0; c++) @(negedge clk);
        check(name, dump_en, 0);
    endtask

    // Dump-buffer model: pop on ack, present head byte, done is a level per channel.
    initial begin
        ch_vld  = '0;
        ch_data = '0;
        ch_done = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NCH; i++) begin
                if (ch_ack[i] && rd[i] < wr[i]) rd[i]++;
                ch_vld[i]          = (rd[i] < wr[i]);
                ch_data[8*i +: 8]  = ch_vld[i] ? mem[i][rd[i]] : 8'h00;
                ch_done[i]         = fin[i];
            end
        end
    end

    // Monitor: compare every strobe, ack and new grant against the queues.
    initial begin
        logic [NCH-1:0] prev_dump;
        prev_dump = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (serial_en) begin
                    n_tx++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_tx: got %02h expected none", serial_tx);
                    end else begin
                        check("tx_byte", serial_tx, exp_q.pop_front());
                    end
                end
                if (ch_ack != '0) begin
                    check("ack_is_grant", ch_ack, dump_en);
                    check("ack_with_strobe", serial_en, 1);
                    for (int i = 0; i < NCH; i++) if (ch_ack[i]) ack_cnt[i]++;
                end
                if (dump_en != '0 && prev_dump == '0) begin
                    if (grant_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_grant: got %0h expected none", dump_en);
                    end else begin
                        check("grant", dump_en, 32'(1) << grant_q.pop_front());
                    end
                end
                check("c_en_gating", c_en, (dump_en == '0));
                prev_dump = dump_en;
            end else begin
                prev_dump = '0;
            end
        end
    end

    // Directed stimulus.
    initial begin
        int base;
        rst_n       = 1'b0;
        ch_req      = '0;
        serial_busy = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_c_en", c_en, 1);
        check("rst_dump_en", dump_en, 0);
        check("rst_ch_ack", ch_ack, 0);
        check("rst_serial_en", serial_en, 0);
        check("rst_serial_tx", serial_tx, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single frame on ch2: A2 11 22 33 03.
        load_byte(2, 8'h11); load_byte(2, 8'h22); load_byte(2, 8'h33);
        fin[2] = 1'b1;
        grant_q.push_back(2);
        exp_q.push_back(8'hA2); exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_q.push_back(8'h33); exp_q.push_back(8'h03);
        @(negedge clk);
        ch_req = 8'h04;
        wait_drain(200, "single_drain");
        ch_req = '0;
        wait_idle(20, "single_idle");
        fin[2] = 1'b0;
        check("single_acks", ack_cnt[2], 3);

        // Reset mid-frame on ch3: header and two bytes, then abort.
        for (int k = 1; k <= 9; k++) load_byte(3, 8'(k));
        fin[3] = 1'b1;
        grant_q.push_back(3);
        exp_q.push_back(8'hA3); exp_q.push_back(8'h01); exp_q.push_back(8'h02);
        @(negedge clk);
        ch_req = 8'h08;
        wait_drain(200, "abort_drain");
        base  = n_tx;
        rst_n = 1'b0;
        #1;
        check("abort_c_en", c_en, 1);
        check("abort_dump_en", dump_en, 0);
        check("abort_serial_en", serial_en, 0);
        check("abort_ch_ack", ch_ack, 0);
        ch_req = '0;
        fin[3] = 1'b0;
        wr[3]  = rd[3];
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_trailer", n_tx, base);
        check("abort_stays_idle", dump_en, 0);

        // Round robin with ch0 and ch7 held: 0,7,0,7 (pointer restarts at 0 after reset).
        load_byte(0, 8'h5A);
        load_byte(7, 8'hC3);
        fin[0] = 1'b1;
        fin[7] = 1'b1;
        grant_q.push_back(0); grant_q.push_back(7);
        grant_q.push_back(0); grant_q.push_back(7);
        exp_q.push_back(8'hA0); exp_q.push_back(8'h5A); exp_q.push_back(8'h01);
        exp_q.push_back(8'hA7); exp_q.push_back(8'hC3); exp_q.push_back(8'h01);
        exp_q.push_back(8'hA0); exp_q.push_back(8'h00);
        exp_q.push_back(8'hA7); exp_q.push_back(8'h00);
        @(negedge clk);
        ch_req = 8'h81;
        wait_drain(300, "rr_drain");
        ch_req = '0;
        wait_idle(20, "rr_idle");
        fin[0] = 1'b0;
        fin[7] = 1'b0;
        check("rr_grants_used", grant_q.size(), 0);

        // Backpressure on ch4 with ch_req dropped mid-frame.
        load_byte(4, 8'h44); load_byte(4, 8'h55);
        fin[4] = 1'b1;
        grant_q.push_back(4);
        exp_q.push_back(8'hA4); exp_q.push_back(8'h44); exp_q.push_back(8'h55);
        exp_q.push_back(8'h02);
        base = n_tx;
        @(negedge clk);
        ch_req = 8'h10;
        for (int c = 0; c < 50 && n_tx == base; c++) @(negedge clk);
        check("bp_header_seen", n_tx, base + 1);
        serial_busy = 1'b1;
        ch_req      = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("bp_no_strobe", serial_en, 0);
            check("bp_no_ack", ch_ack, 0);
        end
        check("bp_grant_held", dump_en, 8'h10);
        check("bp_capture_off", c_en, 0);
        check("bp_byte_held", ack_cnt[4], 0);
        serial_busy = 1'b0;
        wait_drain(100, "bp_drain");
        wait_idle(20, "bp_idle");
        fin[4] = 1'b0;
        check("bp_acks", ack_cnt[4], 2);

        // 256 bytes on ch1 (pointer at 5 searches 5,6,7,0,1): trailer wraps to 00.
        for (int k = 0; k < 256; k++) load_byte(1, 8'(k));
        fin[1] = 1'b1;
        grant_q.push_back(1);
        exp_q.push_back(8'hA1);
        for (int k = 0; k < 256; k++) exp_q.push_back(8'(k));
        exp_q.push_back(8'h00);
        @(negedge clk);
        ch_req = 8'h02;
        wait_drain(2000, "wrap_drain");
        ch_req = '0;
        wait_idle(20, "wrap_idle");
        fin[1] = 1'b0;
        check("wrap_acks", ack_cnt[1], 256);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
